gmii_rx_interface: RTL and testbench



---
 rtl/eth_pkg.sv | 20 ++
 rtl/crc32_d8.sv | 19 +
 rtl/gmii_rx_interface.sv | 196 +++++++++++++++++++
 tb/tb_gmii_rx_interface.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the GMII receive and transmit paths.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  localparam int MIN_LEN_DEF = 64;
  localparam int MAX_LEN_DEF = 1518;

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32, LSB first.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_rx_interface.sv
// GMII receive framer: strips preamble/SFD, writes DA..FCS to the RX FIFO,
// checks CRC and length, and posts one status word per frame.
module gmii_rx_interface
  import eth_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MIN_LEN = MIN_LEN_DEF,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rx_data,
  input  logic             gmii_rx_en,
  input  logic             gmii_rx_er,
  input  logic             fifo_full,
  output logic             fifo_wr,
  output logic [7:0]       fifo_data,
  output logic             status_ready,
  input  logic             status_ack,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_good,
  output logic             crc_err,
  output logic             runt,
  output logic             too_long,
  output logic             rx_err,
  output logic             overflow,
  output logic [7:0]       dropped_frames
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

  rx_state_e        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic             too_long_q, too_long_d, rx_err_q, rx_err_d, overflow_q, overflow_d;
  logic             fifo_wr_q, fifo_wr_d;
  logic [7:0]       fifo_data_q, fifo_data_d;
  logic             status_ready_q, status_ready_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             frame_good_q, frame_good_d, crc_err_q, crc_err_d, runt_q, runt_d;
  logic             too_long_s_q, too_long_s_d, rx_err_s_q, rx_err_s_d;
  logic             overflow_s_q, overflow_s_d;
  logic [7:0]       dropped_q, dropped_d;
  logic             end_frame;
  logic             fin_crc_err, fin_runt;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data    (gmii_rx_data),
    .crc_out (crc_next)
  );

  assign fin_crc_err = (crc_q != CRC_RESIDUE);
  assign fin_runt    = (len_q < MIN_L);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    crc_d       = crc_q;
    too_long_d  = too_long_q;
    rx_err_d    = rx_err_q;
    overflow_d  = overflow_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    end_frame   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_en) begin
          state_d = (gmii_rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!gmii_rx_en) begin
          state_d = ST_IDLE;
        end else if (gmii_rx_data == SFD_BYTE) begin
          state_d    = ST_DATA;
          len_d      = '0;
          crc_d      = CRC_INIT;
          too_long_d = 1'b0;
          rx_err_d   = 1'b0;
          overflow_d = 1'b0;
        end else if (gmii_rx_data != PREAMBLE_BYTE) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (gmii_rx_en) begin
          crc_d = crc_next;
          if (len_q < MAX_L) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              fifo_wr_d   = 1'b1;
              fifo_data_d = gmii_rx_data;
            end
            len_d = len_q + 1'b1;
          end else begin
            too_long_d = 1'b1;
          end
          if (gmii_rx_er) rx_err_d = 1'b1;
        end else begin
          end_frame = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        if (!gmii_rx_en) state_d = ST_IDLE;
      end
    endcase
  end

  // An ack in the frame-end cycle frees the slot, so the new status may load.
  always_comb begin
    status_ready_d = status_ready_q;
    frame_len_d    = frame_len_q;
    frame_good_d   = frame_good_q;
    crc_err_d      = crc_err_q;
    runt_d         = runt_q;
    too_long_s_d   = too_long_s_q;
    rx_err_s_d     = rx_err_s_q;
    overflow_s_d   = overflow_s_q;
    dropped_d      = dropped_q;

    if (end_frame) begin
      if (!status_ready_q || status_ack) begin
        status_ready_d = 1'b1;
        frame_len_d    = len_q;
        crc_err_d      = fin_crc_err;
        runt_d         = fin_runt;
        too_long_s_d   = too_long_q;
        rx_err_s_d     = rx_err_q;
        overflow_s_d   = overflow_q;
        frame_good_d   = !(fin_crc_err || fin_runt || too_long_q || rx_err_q || overflow_q);
      end else if (dropped_q != 8'hFF) begin
        dropped_d = dropped_q + 8'd1;
      end
    end else if (status_ready_q && status_ack) begin
      status_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      crc_q          <= CRC_INIT;
      too_long_q     <= 1'b0;
      rx_err_q       <= 1'b0;
      overflow_q     <= 1'b0;
      fifo_wr_q      <= 1'b0;
      fifo_data_q    <= 8'h00;
      status_ready_q <= 1'b0;
      frame_len_q    <= '0;
      frame_good_q   <= 1'b0;
      crc_err_q      <= 1'b0;
      runt_q         <= 1'b0;
      too_long_s_q   <= 1'b0;
      rx_err_s_q     <= 1'b0;
      overflow_s_q   <= 1'b0;
      dropped_q      <= 8'h00;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      crc_q          <= crc_d;
      too_long_q     <= too_long_d;
      rx_err_q       <= rx_err_d;
      overflow_q     <= overflow_d;
      fifo_wr_q      <= fifo_wr_d;
      fifo_data_q    <= fifo_data_d;
      status_ready_q <= status_ready_d;
      frame_len_q    <= frame_len_d;
      frame_good_q   <= frame_good_d;
      crc_err_q      <= crc_err_d;
      runt_q         <= runt_d;
      too_long_s_q   <= too_long_s_d;
      rx_err_s_q     <= rx_err_s_d;
      overflow_s_q   <= overflow_s_d;
      dropped_q      <= dropped_d;
    end
  end

  assign fifo_wr        = fifo_wr_q;
  assign fifo_data      = fifo_data_q;
  assign status_ready   = status_ready_q;
  assign frame_len      = frame_len_q;
  assign frame_good     = frame_good_q;
  assign crc_err        = crc_err_q;
  assign runt           = runt_q;
  assign too_long       = too_long_s_q;
  assign rx_err         = rx_err_s_q;
  assign overflow       = overflow_s_q;
  assign dropped_frames = dropped_q;

endmodule

// File: tb/tb_gmii_rx_interface.sv
// Directed bench for gmii_rx_interface: CRC, length, overflow, handshake and reset cases.
module tb_gmii_rx_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rx_data = 8'h00;
  logic        gmii_rx_en = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
  logic        status_ready;
  logic        status_ack = 1'b0;
  logic [10:0] frame_len;
  logic        frame_good, crc_err, runt, too_long, rx_err, overflow;
  logic [7:0]  dropped_frames;

  int tests = 0;
  int fails = 0;

  logic [7:0] tx_q[$];
  logic [7:0] wr_q[$];
  int         wr_cnt = 0;
  int         full_lo = -1, full_hi = -1, er_at = -1;
  logic       ack_at_end = 1'b0;

  gmii_rx_interface dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gmii_rx_data   (gmii_rx_data),
    .gmii_rx_en     (gmii_rx_en),
    .gmii_rx_er     (gmii_rx_er),
    .fifo_full      (fifo_full),
    .fifo_wr        (fifo_wr),
    .fifo_data      (fifo_data),
    .status_ready   (status_ready),
    .status_ack     (status_ack),
    .frame_len      (frame_len),
    .frame_good     (frame_good),
    .crc_err        (crc_err),
    .runt           (runt),
    .too_long       (too_long),
    .rx_err         (rx_err),
    .overflow       (overflow),
    .dropped_frames (dropped_frames)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      wr_cnt <= wr_cnt + 1;
      wr_q.push_back(fifo_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " fifo_wr"}, 32'(fifo_wr), 0);
    check({tag, " fifo_data"}, 32'(fifo_data), 0);
    check({tag, " status_ready"}, 32'(status_ready), 0);
    check({tag, " frame_len"}, 32'(frame_len), 0);
    check({tag, " frame_good"}, 32'(frame_good), 0);
    check({tag, " flags"}, {27'd0, crc_err, runt, too_long, rx_err, overflow}, 0);
    check({tag, " dropped"}, 32'(dropped_frames), 0);
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) begin
      if ((c[0] ^ d[b]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
      else c = c >> 1;
    end
    return c;
  endfunction

  task automatic clear_mon();
    wr_cnt = 0;
    wr_q.delete();
  endtask

  task automatic push_pre();
    tx_q.delete();
    for (int i = 0; i < 7; i++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
  endtask

  task automatic push_fcs(input int first);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = first; i < tx_q.size(); i++) c = crc_step(c, tx_q[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
  endtask

  task automatic build_good(input logic flip);
    push_pre();
    for (int i = 0; i < 60; i++) tx_q.push_back(8'h00);
    push_fcs(8);
    if (flip) tx_q[tx_q.size()-1] = ~tx_q[tx_q.size()-1];
  endtask

  task automatic build_a();
    logic [7:0] vec [13];
    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    push_pre();
    for (int i = 0; i < 13; i++) tx_q.push_back(vec[i]);
  endtask

  // Drives the queue, then one idle cycle that the DUT samples as frame end.
  task automatic send_raw();
    clear_mon();
    foreach (tx_q[i]) begin
      gmii_rx_en   = 1'b1;
      gmii_rx_data = tx_q[i];
      gmii_rx_er   = (i == er_at);
      fifo_full    = (i >= full_lo) && (i <= full_hi);
      @(posedge clk); #1;
    end
    gmii_rx_en   = 1'b0;
    gmii_rx_er   = 1'b0;
    fifo_full    = 1'b0;
    gmii_rx_data = 8'h00;
    status_ack   = ack_at_end;
    @(posedge clk); #1;
    status_ack   = 1'b0;
  endtask

  task automatic do_ack();
    status_ack = 1'b1;
    @(posedge clk); #1;
    status_ack = 1'b0;
  endtask

  initial begin
    int bad;

    #2;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset");

    // CRC check-string frame: short but correct FCS
    build_a();
    send_raw();
    check("a wr_cnt", wr_cnt, 13);
    bad = 0;
    for (int i = 0; i < 13; i++) if (wr_q.size() <= i || wr_q[i] !== tx_q[8+i]) bad++;
    check("a bytes", bad, 0);
    check("a ready", 32'(status_ready), 1);
    check("a len", 32'(frame_len), 13);
    check("a crc_err", 32'(crc_err), 0);
    check("a runt", 32'(runt), 1);
    check("a good", 32'(frame_good), 0);
    do_ack();
    check("a ack clears", 32'(status_ready), 0);
    do_ack();
    check("ack while idle", 32'(status_ready), 0);

    build_good(1'b0);
    send_raw();
    check("good wr_cnt", wr_cnt, 64);
    check("good len", 32'(frame_len), 64);
    check("good good", 32'(frame_good), 1);
    check("good flags", {27'd0, crc_err, runt, too_long, rx_err, overflow}, 0);
    do_ack();

    build_good(1'b1);
    send_raw();
    check("flip crc_err", 32'(crc_err), 1);
    check("flip good", 32'(frame_good), 0);
    check("flip len", 32'(frame_len), 64);
    do_ack();

    push_pre();
    for (int i = 0; i < 1600; i++) tx_q.push_back(8'(i));
    send_raw();
    check("long wr_cnt", wr_cnt, 1518);
    check("long len", 32'(frame_len), 1518);
    check("long too_long", 32'(too_long), 1);
    check("long good", 32'(frame_good), 0);
    do_ack();

    push_pre();
    for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
    full_lo = 8 + 10; full_hi = 8 + 12; er_at = 8 + 20;
    send_raw();
    full_lo = -1; full_hi = -1; er_at = -1;
    check("ovf wr_cnt", wr_cnt, 61);
    check("ovf byte9", (wr_q.size() > 10) ? 32'(wr_q[9]) : 32'hFFFF, 9);
    check("ovf byte after gap", (wr_q.size() > 10) ? 32'(wr_q[10]) : 32'hFFFF, 13);
    check("ovf len", 32'(frame_len), 64);
    check("ovf overflow", 32'(overflow), 1);
    check("ovf rx_err", 32'(rx_err), 1);
    check("ovf good", 32'(frame_good), 0);
    do_ack();

    // Back-to-back, no ack: second status is lost
    build_a();
    send_raw();
    build_good(1'b0);
    send_raw();
    check("b2b wr_cnt", wr_cnt, 64);
    check("b2b ready", 32'(status_ready), 1);
    check("b2b kept len", 32'(frame_len), 13);
    check("b2b kept runt", 32'(runt), 1);
    check("b2b dropped", 32'(dropped_frames), 1);

    build_good(1'b0);
    ack_at_end = 1'b1;
    send_raw();
    ack_at_end = 1'b0;
    check("ackend ready", 32'(status_ready), 1);
    check("ackend len", 32'(frame_len), 64);
    check("ackend good", 32'(frame_good), 1);
    check("ackend dropped", 32'(dropped_frames), 1);
    do_ack();
    check("ackend cleared", 32'(status_ready), 0);

    tx_q.delete();
    tx_q.push_back(8'h12);
    for (int i = 0; i < 6; i++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'hA0 + 8'(i));
    send_raw();
    check("bad start wr", wr_cnt, 0);
    check("bad start ready", 32'(status_ready), 0);

    tx_q.delete();
    tx_q.push_back(8'hD5);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'hA0 + 8'(i));
    send_raw();
    check("bare sfd wr", wr_cnt, 0);
    check("bare sfd ready", 32'(status_ready), 0);

    // Reset in the middle of a frame with a status pending
    build_good(1'b0);
    send_raw();
    check("pre-rst ready", 32'(status_ready), 1);
    push_pre();
    for (int i = 0; i < 10; i++) tx_q.push_back(8'hA0 + 8'(i));
    clear_mon();
    foreach (tx_q[i]) begin
      gmii_rx_en = 1'b1;
      gmii_rx_data = tx_q[i];
      @(posedge clk); #1;
    end
    check("mid wr seen", 32'(fifo_wr), 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 20; i++) begin
      gmii_rx_data = 8'hB0 + 8'(i);
      @(posedge clk); #1;
    end
    gmii_rx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post-rst wr", wr_cnt, 0);
    check("post-rst ready", 32'(status_ready), 0);
    check("post-rst dropped", 32'(dropped_frames), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
